// File: rtl/ip_pkg.sv
// Shared types for the cell result UART path: pixel layout, UART FSM
// states, the default frame header and the per-frame byte selector.
package ip_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Byte idx of a frame: 0 is the header, then R, G, B.
  function automatic logic [7:0] frame_byte(input pixel_t p, input logic [1:0] idx,
                                            input logic [7:0] sync);
    case (idx)
      2'd0:    return sync;
      2'd1:    return p.r;
      2'd2:    return p.g;
      default: return p.b;
    endcase
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer. A start pulse loads a byte; done pulses in the last
// STOP cycle, and a start in that same cycle chains the next byte with no
// idle gap on the line.
module uart_byte_tx
  import ip_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_done,
  output logic       o_idle
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  tx_state_t     r_state;
  tx_state_t     w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_byte;
  logic          w_last;
  logic          w_load;

  assign w_last = (r_cnt == CW'(CLKS_PER_BIT - 1));
  assign w_load = i_start && ((r_state == IDLE) || ((r_state == STOP) && w_last));
  assign o_idle = (r_state == IDLE);

  // State, bit-period counter and bit index.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) || w_last) r_cnt <= '0;
      else                             r_cnt <= r_cnt + 1'b1;
      if ((r_state == DATA) && w_last) r_bit <= r_bit + 3'd1;
    end
  end

  // Byte being shifted out; only meaningful once loaded.
  always_ff @(posedge i_clk) begin
    if (w_load) r_byte <= i_data;
  end

  // Next state, line level and done pulse.
  always_comb begin
    w_state_nxt = r_state;
    o_tx        = 1'b1;
    o_done      = 1'b0;
    case (r_state)
      IDLE:  if (i_start) w_state_nxt = START;
      START: begin
        o_tx = 1'b0;
        if (w_last) w_state_nxt = DATA;
      end
      DATA:  begin
        o_tx = r_byte[r_bit];
        if (w_last && (r_bit == 3'd7)) w_state_nxt = STOP;
      end
      STOP:  begin
        if (w_last) begin
          o_done      = 1'b1;
          w_state_nxt = i_start ? START : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/cell_result_uart_tx.sv
// Drains processed pixels from the cell interface into a small FIFO and
// sends each as a 4-byte UART frame: header, R, G, B.
module cell_result_uart_tx
  import ip_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         FIFO_DEPTH   = 8,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF
) (
  input  logic                          SYSCLK,
  input  logic                          RST,
  input  logic                          pixel_strobe,
  input  logic [23:0]                   pixel_data,
  output logic                          pixel_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  pixel_t        r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [LW-1:0] r_level;
  logic [7:0]    r_drop;
  pixel_t        r_frame;
  logic [1:0]    r_byte_idx;

  logic       w_full;
  logic       w_empty;
  logic       w_pop;
  logic       w_push;
  logic       w_idle;
  logic       w_done;
  logic       w_start;
  logic [1:0] w_idx_nxt;
  logic [7:0] w_byte;

  assign w_full    = (r_level == LW'(FIFO_DEPTH));
  assign w_empty   = (r_level == '0);
  // A new pixel starts either from idle or straight after the last stop bit.
  assign w_pop     = !w_empty && (w_idle || (w_done && (r_byte_idx == 2'd3)));
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_push    = pixel_strobe && (!w_full || w_pop);
  assign w_idx_nxt = r_byte_idx + 2'd1;
  assign w_start   = w_pop || (w_done && (r_byte_idx != 2'd3));
  assign w_byte    = (w_done && (r_byte_idx != 2'd3)) ?
                     frame_byte(r_frame, w_idx_nxt, SYNC_BYTE) : SYNC_BYTE;

  assign pixel_ready = !w_full;
  assign busy        = !w_idle || !w_empty;
  assign fifo_level  = r_level;
  assign drop_cnt    = r_drop;

  // FIFO pointers, occupancy and saturating drop counter.
  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      r_drop  <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (pixel_strobe && !w_push && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
    end
  end

  // FIFO storage and the frame register; pixel_data is only sampled on push.
  always_ff @(posedge SYSCLK) begin
    if (w_push) r_mem[r_wr] <= pixel_t'(pixel_data);
    if (w_pop)  r_frame     <= r_mem[r_rd];
  end

  // Byte position within the current frame.
  always_ff @(posedge SYSCLK) begin
    if (RST)         r_byte_idx <= 2'd0;
    else if (w_pop)  r_byte_idx <= 2'd0;
    else if (w_done) r_byte_idx <= w_idx_nxt;
  end

  uart_byte_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte_tx (
    .i_clk   (SYSCLK),
    .i_rst   (RST),
    .i_start (w_start),
    .i_data  (w_byte),
    .o_tx    (tx),
    .o_done  (w_done),
    .o_idle  (w_idle)
  );

endmodule
